// File: rtl/data_mem_controller.sv
// MEM-stage data-memory controller: runs one load/store per EX/MEM request over a
// req/ack bus, formats store byte lanes and sign/zero-extends load data.
module data_mem_controller (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_MEM_READ,
  input  logic        MEM_MEM_WRITE,
  input  logic [2:0]  MEM_FUNC3,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  output logic [3:0]  BUS_BE,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ACK,
  output logic [31:0] LOAD_DATA,
  output logic        BUSYWAIT,
  output logic        ACCESS_FAULT
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] load_q, load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  logic        req;
  logic        f3_legal;
  logic        aligned;
  logic        start_ok;
  logic [1:0]  a;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] load_fmt;
  logic [3:0][7:0] rd_bytes;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign a = MEM_ADDRESS[1:0];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_bytes[gi] = BUS_RDATA[8*gi +: 8];
  end

  // Request legality: size/sign code must exist for the direction, and the
  // address must be naturally aligned for the access width.
  always_comb begin
    req = MEM_MEM_READ | MEM_MEM_WRITE;
    if (MEM_MEM_READ) begin
      f3_legal = (MEM_FUNC3 != 3'b011) && (MEM_FUNC3[2:1] != 2'b11);
    end else begin
      f3_legal = !MEM_FUNC3[2] && (MEM_FUNC3[1:0] != 2'b11);
    end
    case (MEM_FUNC3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !a[0];
      2'b10:   aligned = (a == 2'b00);
      default: aligned = 1'b0;
    endcase
    start_ok = req && f3_legal && aligned;
  end

  always_comb begin
    case (MEM_FUNC3[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << a;
        wdata_fmt = {4{MEM_WRITE_DATA[7:0]}};
      end
      2'b01: begin
        be_fmt    = a[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{MEM_WRITE_DATA[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = MEM_WRITE_DATA;
      end
    endcase
  end

  always_comb begin
    rd_byte = rd_bytes[off_q];
    rd_half = off_q[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_fmt = {24'd0, rd_byte};
      3'b101:  load_fmt = {16'd0, rd_half};
      default: load_fmt = BUS_RDATA;
    endcase
  end

  // Bus outputs are captured once on entry to ACCESS and held until the next
  // access; a read is any latched access with BUS_WE low.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    load_d      = load_q;
    f3_d        = f3_q;
    off_d       = off_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_ACCESS;
          bus_req_d   = 1'b1;
          bus_we_d    = MEM_MEM_WRITE & ~MEM_MEM_READ;
          bus_addr_d  = {MEM_ADDRESS[31:2], 2'b00};
          bus_wdata_d = wdata_fmt;
          bus_be_d    = be_fmt;
          f3_d        = MEM_FUNC3;
          off_d       = a;
        end
      end
      ST_ACCESS: begin
        if (BUS_ACK) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            load_d = load_fmt;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
      load_q      <= 32'd0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      load_q      <= load_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign BUS_REQ      = bus_req_q;
  assign BUS_WE       = bus_we_q;
  assign BUS_ADDR     = bus_addr_q;
  assign BUS_WDATA    = bus_wdata_q;
  assign BUS_BE       = bus_be_q;
  assign LOAD_DATA    = load_q;
  assign BUSYWAIT     = !RST && (((state_q == ST_IDLE) && start_ok) || (state_q == ST_ACCESS));
  assign ACCESS_FAULT = !RST && (state_q == ST_IDLE) && req && !start_ok;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: each transaction is expanded into per-cycle
// expectations from the access rules and checked cycle by cycle.
`timescale 1ns/1ps
module tb_data_mem_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MEM_MEM_READ = 1'b0;
  logic        MEM_MEM_WRITE = 1'b0;
  logic [2:0]  MEM_FUNC3 = 3'd0;
  logic [31:0] MEM_ADDRESS = 32'd0;
  logic [31:0] MEM_WRITE_DATA = 32'd0;
  logic        BUS_REQ;
  logic        BUS_WE;
  logic [31:0] BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [3:0]  BUS_BE;
  logic [31:0] BUS_RDATA = 32'd0;
  logic        BUS_ACK = 1'b0;
  logic [31:0] LOAD_DATA;
  logic        BUSYWAIT;
  logic        ACCESS_FAULT;

  data_mem_controller dut (
    .CLK(CLK), .RST(RST),
    .MEM_MEM_READ(MEM_MEM_READ), .MEM_MEM_WRITE(MEM_MEM_WRITE),
    .MEM_FUNC3(MEM_FUNC3), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_BE(BUS_BE), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .LOAD_DATA(LOAD_DATA), .BUSYWAIT(BUSYWAIT), .ACCESS_FAULT(ACCESS_FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        chk;
    logic        busy;
    logic        fault;
    logic        req;
    logic        chk_bus;
    logic        we;
    logic        chk_wd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load;
    logic [3:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_load = 32'd0;
  int          busy_run = 0;
  int          last_run = 0;
  logic        last_we = 1'b0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [3:0]  last_be = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic exp_t blank(input logic [31:0] ld);
    exp_t e;
    e.chk = 1'b1;  e.busy = 1'b0;  e.fault = 1'b0; e.req = 1'b0;
    e.chk_bus = 1'b0; e.we = 1'b0; e.chk_wd = 1'b0;
    e.addr = 32'd0; e.wdata = 32'd0; e.be = 4'd0; e.load = ld;
    return e;
  endfunction

  // Reference rules, expressed by access width in bytes.
  function automatic int width_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic legal(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] adr);
    logic ok_f3;
    if (rd) ok_f3 = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else    ok_f3 = f3 inside {3'b000, 3'b001, 3'b010};
    return (rd | wr) && ok_f3 && ((adr % 32'(width_of(f3))) == 32'd0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] adr);
    int n;
    n = width_of(f3);
    return 4'(((1 << n) - 1) << adr[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (width_of(f3))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] adr,
                                             input logic [31:0] rdt);
    int n;
    logic [31:0] v, mask;
    n = width_of(f3);
    v = rdt >> (8 * adr[1:0]);
    if (n < 4) begin
      mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // One clock cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input logic rst, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] adr, input logic [31:0] wd, input logic ack,
                      input logic [31:0] rdt, input exp_t e);
    @(posedge CLK);
    #1;
    RST = rst; MEM_MEM_READ = rd; MEM_MEM_WRITE = wr; MEM_FUNC3 = f3;
    MEM_ADDRESS = adr; MEM_WRITE_DATA = wd; BUS_ACK = ack; BUS_RDATA = rdt;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_step(input logic ack);
    step(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, ack, $urandom,
         blank(m_load));
  endtask

  // Full access as the frozen pipeline presents it: inputs held throughout.
  task automatic txn(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] adr, input logic [31:0] wd, input int nwait,
                     input logic [31:0] rdt);
    exp_t e;
    e = blank(m_load);
    if (!(rd | wr)) begin
      step(1'b0, rd, wr, f3, adr, wd, 1'($urandom_range(0, 1)), $urandom, e);
      $display("txn %s: no request", nm);
      return;
    end
    if (!legal(rd, wr, f3, adr)) begin
      e.fault = 1'b1;
      step(1'b0, rd, wr, f3, adr, wd, 1'($urandom_range(0, 1)), $urandom, e);
      $display("txn %s: rd=%0b wr=%0b f3=%03b addr=%h faulted", nm, rd, wr, f3, adr);
      return;
    end
    e.busy = 1'b1;
    step(1'b0, rd, wr, f3, adr, wd, 1'($urandom_range(0, 1)), $urandom, e);
    e.req = 1'b1; e.chk_bus = 1'b1; e.we = wr & ~rd;
    e.addr = {adr[31:2], 2'b00}; e.be = model_be(f3, adr);
    e.chk_wd = e.we; e.wdata = model_wdata(f3, wd);
    for (int i = 0; i <= nwait; i++) begin
      step(1'b0, rd, wr, f3, adr, wd, (i == nwait), (i == nwait) ? rdt : $urandom, e);
    end
    if (rd) m_load = model_load(f3, adr, rdt);
    e = blank(m_load);
    step(1'b0, rd, wr, f3, adr, wd, 1'($urandom_range(0, 1)), $urandom, e);
    $display("txn %s: rd=%0b wr=%0b f3=%03b addr=%h wait=%0d load=%h", nm, rd, wr, f3, adr,
             nwait, m_load);
  endtask

  task automatic reset_mid();
    exp_t e;
    logic [31:0] adr;
    adr = 32'h0000_0440;
    e = blank(m_load);
    e.busy = 1'b1;
    step(1'b0, 1'b1, 1'b0, 3'b010, adr, 32'd0, 1'b0, 32'd0, e);
    e.req = 1'b1; e.chk_bus = 1'b1; e.we = 1'b0; e.addr = adr; e.be = 4'hF;
    step(1'b0, 1'b1, 1'b0, 3'b010, adr, 32'd0, 1'b0, 32'h1111_2222, e);
    e.busy = 1'b0;
    step(1'b1, 1'b1, 1'b0, 3'b010, adr, 32'd0, 1'b0, 32'h3333_4444, e);
    m_load = 32'd0;
    e = blank(32'd0);
    e.chk_bus = 1'b1; e.chk_wd = 1'b1;
    step(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 32'hCAFE_F00D, e);
    step(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0, e);
    $display("txn reset_mid: read at %h abandoned by reset", adr);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      if (cur.chk) begin
        chk("busywait", 32'(BUSYWAIT), 32'(cur.busy));
        chk("access_fault", 32'(ACCESS_FAULT), 32'(cur.fault));
        chk("bus_req", 32'(BUS_REQ), 32'(cur.req));
        chk("load_data", LOAD_DATA, cur.load);
        if (cur.chk_bus) begin
          chk("bus_we", 32'(BUS_WE), 32'(cur.we));
          chk("bus_addr", BUS_ADDR, cur.addr);
          chk("bus_be", 32'(BUS_BE), 32'(cur.be));
        end
        if (cur.chk_wd) chk("bus_wdata", BUS_WDATA, cur.wdata);
      end
    end
    if (BUS_REQ === 1'b1) begin
      last_we = BUS_WE; last_addr = BUS_ADDR; last_wdata = BUS_WDATA; last_be = BUS_BE;
    end
    if (BUSYWAIT === 1'b1) begin
      busy_run++;
    end else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic rd, wr;
    e = blank(32'd0);
    e.chk = 1'b0;
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, e);
    e = blank(32'd0);
    e.chk_bus = 1'b1; e.chk_wd = 1'b1;
    step(1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0101, 32'd0, 1'b1, 32'd0, e);
    idle_step(1'b1);

    txn("lw_0x100", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    settle();
    chk("lw_busy_cycles", 32'(last_run), 32'd5);
    chk("lw_load_literal", LOAD_DATA, 32'hDEAD_BEEF);
    chk("lw_addr_literal", last_addr, 32'h0000_0100);
    chk("lw_be_literal", 32'(last_be), 32'h0000_000F);
    chk("lw_we_literal", 32'(last_we), 32'd0);
    chk("lw_req_done", 32'(BUS_REQ), 32'd0);

    txn("sb_0x203", 1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h1234_56AB, 0, 32'h0);
    settle();
    chk("sb_busy_cycles", 32'(last_run), 32'd2);
    chk("sb_addr_literal", last_addr, 32'h0000_0200);
    chk("sb_be_literal", 32'(last_be), 32'h0000_0008);
    chk("sb_wdata_literal", last_wdata, 32'hABAB_ABAB);
    chk("sb_we_literal", 32'(last_we), 32'd1);

    txn("lb_off0", 1'b1, 1'b0, 3'b000, 32'h0000_0300, 32'h0, 1, 32'h80F1_7F80);
    settle();
    chk("lb_literal", LOAD_DATA, 32'hFFFF_FF80);
    txn("lbu_off0", 1'b1, 1'b0, 3'b100, 32'h0000_0300, 32'h0, 0, 32'h80F1_7F80);
    settle();
    chk("lbu_literal", LOAD_DATA, 32'h0000_0080);
    txn("lh_off2", 1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0, 2, 32'h80F1_7F80);
    settle();
    chk("lh_literal", LOAD_DATA, 32'hFFFF_80F1);
    txn("lhu_off2", 1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 0, 32'h80F1_7F80);
    settle();
    chk("lhu_literal", LOAD_DATA, 32'h0000_80F1);

    txn("lw_0x102", 1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h0);
    settle();
    chk("lw_mis_fault", 32'(ACCESS_FAULT), 32'd1);
    chk("lw_mis_busy", 32'(BUSYWAIT), 32'd0);
    txn("sh_0x101", 1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'hFFFF_FFFF, 0, 32'h0);
    settle();
    chk("sh_mis_fault", 32'(ACCESS_FAULT), 32'd1);
    txn("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    settle();
    chk("f3_011_fault", 32'(ACCESS_FAULT), 32'd1);
    chk("fault_req_low", 32'(BUS_REQ), 32'd0);
    chk("fault_load_kept", LOAD_DATA, 32'h0000_80F1);
    idle_step(1'b0);

    idle_step(1'b1);
    txn("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h5555_AAAA, 1, 32'h1357_2468);
    settle();
    chk("rdwr_is_read", 32'(last_we), 32'd0);
    chk("rdwr_load", LOAD_DATA, 32'h1357_2468);

    reset_mid();
    settle();
    chk("rst_mid_load_cleared", LOAD_DATA, 32'd0);
    chk("rst_mid_req_low", 32'(BUS_REQ), 32'd0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle_step(1'($urandom_range(0, 1)));
      end else begin
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        txn("rand", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom_range(0, 3), $urandom);
      end
    end

    idle_step(1'b0);
    idle_step(1'b0);
    settle();
    chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
